// File: rtl/can_rx_destuff.sv
// CAN receive-path bit de-stuffer.
// Removes stuff bits from the sampled bus stream inside the stuff window,
// flags stuff errors, and forwards de-stuffed bits, a saturating bit count
// and assembled bytes (MSB = first received) to the frame decoder.
module can_rx_destuff #(
    parameter int STUFF_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       din_valid,
    output logic       dout,
    output logic       dout_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] bit_cnt,
    output logic       stuff_err
);

    localparam int               RUN_W   = $clog2(STUFF_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [RUN_W-1:0] run;       // identical consecutive bits seen, 0..STUFF_LEN
    logic             last;      // previous bus bit (stuff bits included)
    logic [2:0]       byte_pos;  // emitted bits modulo 8 within the window

    // Per-bit decode signals
    logic             opening;   // IDLE seeing en: window opens on this edge
    logic             take;      // a bus bit is processed this cycle
    logic [RUN_W-1:0] run_cur;   // run length as seen by this bit
    logic             at_limit;  // next bit must be a stuff bit
    logic             is_stuff;
    logic             is_err;
    logic             emit;
    logic [RUN_W-1:0] run_nxt;
    logic [7:0]       cnt_base;
    logic [7:0]       byte_base;
    logic [2:0]       pos_base;

    // Classify the incoming bit; a window opening this cycle sees cleared counters.
    always_comb begin
        // NOTE: every signal gets an unconditional value first so no latch is inferred.
        opening   = (state == IDLE) && en;
        take      = din_valid && en && (state != ERR);
        run_cur   = opening ? '0 : run;
        cnt_base  = opening ? 8'h00 : bit_cnt;
        byte_base = opening ? 8'h00 : byte_out;
        pos_base  = opening ? 3'd0 : byte_pos;
        at_limit  = (run_cur == RUN_MAX);
        is_stuff  = take && at_limit && (din != last);
        is_err    = take && at_limit && (din == last);
        emit      = take && !at_limit;

        run_nxt = RUN_W'(1);
        if (!is_stuff && ((run_cur == '0) || (din == last))) begin
            run_nxt = run_cur + RUN_W'(1);
        end
    end

    // Next-state logic: en gates the window, a stuff error parks us in ERR.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
                     else if (is_err) state_nxt = ERR;
            ERR:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run tracking, byte assembly, bit counting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= '0;
            last       <= 1'b0;
            byte_pos   <= 3'd0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            bit_cnt    <= 8'h00;
            stuff_err  <= 1'b0;
        end else begin
            dout_valid <= emit;
            byte_valid <= emit && (pos_base == 3'd7);

            // Error flag survives into IDLE and clears only when a window opens.
            if (is_err) begin
                stuff_err <= 1'b1;
            end else if (opening) begin
                stuff_err <= 1'b0;
            end

            if (emit) begin
                dout     <= din;
                byte_out <= {byte_base[6:0], din};
                bit_cnt  <= (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
                byte_pos <= pos_base + 3'd1;
            end else if (opening) begin
                byte_out <= 8'h00;
                bit_cnt  <= 8'h00;
                byte_pos <= 3'd0;
            end

            // A stuff bit starts a new run; an erroring bit changes nothing.
            if (take && !is_err) begin
                run  <= run_nxt;
                last <= din;
            end else if (opening) begin
                run <= '0;
            end
        end
    end

endmodule

// File: tb/tb_can_rx_destuff.sv
// Self-checking bench for can_rx_destuff: directed vector table, hand-written
// corner sequences, and randomized windows against a queue-based model.
module tb_can_rx_destuff;

    localparam int STUFF_LEN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       dout;
    logic       dout_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [7:0] bit_cnt;
    logic       stuff_err;

    int n_vec = 0;
    int n_err = 0;

    can_rx_destuff #(.STUFF_LEN(STUFF_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .bit_cnt    (bit_cnt),
        .stuff_err  (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit       dv;
        bit       din;
        bit       e_dv;
        bit       e_dout;
        bit       e_bv;
        bit       e_err;
        bit [7:0] e_cnt;
        bit [7:0] e_byte;
    } vec_t;

    vec_t tbl[$];
    bit   ch_in [12];
    bit   ch_em [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input bit e, input bit v, input bit d);
        @(negedge clk);
        en = e;
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Idle cycle keeping strobes at least two cycles apart.
    task automatic gap();
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input bit e_dv, input bit e_dout, input bit e_bv,
                             input bit e_err, input bit [7:0] e_cnt, input bit [7:0] e_byte);
        check({tag, ".dout_valid"}, dout_valid, e_dv);
        if (e_dv) check({tag, ".dout"}, dout, e_dout);
        check({tag, ".byte_valid"}, byte_valid, e_bv);
        check({tag, ".stuff_err"}, stuff_err, e_err);
        check({tag, ".bit_cnt"}, bit_cnt, e_cnt);
        check({tag, ".byte_out"}, byte_out, e_byte);
    endtask

    // Last (up to) 8 emitted bits, first received in the MSB position.
    function automatic bit [7:0] last_byte(input bit q[$]);
        bit [7:0] b = 8'h00;
        int       start = (q.size() > 8) ? q.size() - 8 : 0;
        for (int i = start; i < q.size(); i++) b = {b[6:0], q[i]};
        return b;
    endfunction

    // A stuff bit is due once the last STUFF_LEN bus bits of the window are identical.
    function automatic bit stuff_due(input bit h[$]);
        if (h.size() < STUFF_LEN) return 1'b0;
        for (int i = h.size() - STUFF_LEN; i < h.size(); i++)
            if (h[i] != h[h.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    // One randomized window checked against the reference model.
    task automatic rand_window(input int nbits, input bit same_cycle_open, input bit allow_err);
        bit hist[$];
        bit emitted[$];
        bit err = 1'b0;
        bit due, d, e_emit, e_bv;
        int cnt;
        if (!same_cycle_open) begin
            drive(1'b1, 1'b0, 1'b0);
            check("rnd.open.bit_cnt", bit_cnt, 8'd0);
            check("rnd.open.stuff_err", stuff_err, 1'b0);
            check("rnd.open.byte_out", byte_out, 8'h00);
        end
        for (int i = 0; i < nbits; i++) begin
            due = stuff_due(hist);
            if (err) begin
                d = 1'($urandom_range(0, 1));
            end else if (due) begin
                d = (allow_err && $urandom_range(0, 9) == 0) ? hist[$] : !hist[$];
            end else if (hist.size() > 0 && $urandom_range(0, 3) != 0) begin
                d = hist[$];
            end else begin
                d = 1'($urandom_range(0, 1));
            end
            e_emit = 1'b0;
            if (!err) begin
                if (due && d == hist[$]) begin
                    err = 1'b1;
                end else begin
                    hist.push_back(d);
                    if (!due) begin
                        emitted.push_back(d);
                        e_emit = 1'b1;
                    end
                end
            end
            e_bv = e_emit && (emitted.size() % 8 == 0);
            cnt = (emitted.size() > 255) ? 255 : emitted.size();
            drive(1'b1, 1'b1, d);
            check_all("rnd", e_emit, d, e_bv, err, 8'(cnt), last_byte(emitted));
            gap();
            check("rnd.gap.dout_valid", dout_valid, 1'b0);
            check("rnd.gap.byte_valid", byte_valid, 1'b0);
        end
        cnt = (emitted.size() > 255) ? 255 : emitted.size();
        drive(1'b0, 1'b0, 1'b0);
        check_all("rnd.close", 1'b0, 1'b0, 1'b0, err, 8'(cnt), last_byte(emitted));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int emitted_n;
        int  pos;
        bit  emq[$];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("reset.dout", dout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: stuff-bit drop, then stuff error and its clearing.
        //              en dv din e_dv e_dout e_bv e_err e_cnt  e_byte
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd1, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd2, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd3, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd4, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd5, 8'h00});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 8'd5, 8'h00});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 8'd6, 8'h01});
        tbl.push_back('{1, 1, 1, 1, 1, 0, 0, 8'd7, 8'h03});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 8'd7, 8'h03});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd1, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd2, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd3, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd4, 8'h00});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 8'd5, 8'h00});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 8'd5, 8'h00});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 1, 8'd5, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 8'd5, 8'h00});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 8'd0, 8'h00});
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].dv, tbl[i].din);
            check_all($sformatf("tbl[%0d]", i), tbl[i].e_dv, tbl[i].e_dout, tbl[i].e_bv,
                      tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_byte);
            gap();
        end

        // Chained stuffing: two stuff bits dropped, byte at the 8th emitted bit.
        ch_in = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        ch_em = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        emitted_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (ch_em[i]) emitted_n++;
            drive(1'b1, 1'b1, ch_in[i]);
            check("chain.dout_valid", dout_valid, ch_em[i]);
            if (ch_em[i]) check("chain.dout", dout, ch_in[i]);
            check("chain.byte_valid", byte_valid, (i == 8));
            if (i == 8) check("chain.byte_out", byte_out, 8'hF8);
            check("chain.bit_cnt", bit_cnt, 8'(emitted_n));
            gap();
        end
        check("chain.final.byte_out", byte_out, 8'hE1);
        check("chain.final.stuff_err", stuff_err, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // 0xAA byte, three more bits, then the window closes mid-byte.
        for (int i = 0; i < 11; i++) begin
            pos = (i < 8) ? ((i % 2 == 0) ? 1 : 0) : ((i == 10) ? 0 : 1);
            drive(1'b1, 1'b1, 1'(pos));
            check("aa.dout_valid", dout_valid, 1'b1);
            check("aa.byte_valid", byte_valid, (i == 7));
            if (i == 7) begin
                check("aa.byte_out", byte_out, 8'hAA);
                check("aa.bit_cnt", bit_cnt, 8'd8);
            end
            gap();
        end
        drive(1'b0, 1'b0, 1'b0);
        check_all("aa.close", 1'b0, 1'b0, 1'b0, 1'b0, 8'd11, 8'h56);
        gap();
        check("aa.close2.byte_valid", byte_valid, 1'b0);

        // Reset mid-frame after 20 bits, with en and a strobe present.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'(i % 2));
            gap();
        end
        check("rst.pre.bit_cnt", bit_cnt, 8'd20);
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b1;
        din = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rst.mid.dout", dout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b1);
        check_all("rst.after", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'h01);
        gap();
        drive(1'b0, 1'b0, 1'b0);

        // en low on a strobe cycle: bit ignored, count unchanged.
        drive(1'b1, 1'b1, 1'b1); gap();
        drive(1'b1, 1'b1, 1'b0); gap();
        drive(1'b1, 1'b1, 1'b1); gap();
        drive(1'b0, 1'b1, 1'b0);
        check_all("enlow", 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'h05);
        gap();

        // Randomized windows: one long error-free window to reach saturation, then mixed.
        rand_window(300, 1'b0, 1'b0);
        for (int w = 0; w < 25; w++) begin
            rand_window(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1'b1);
        end
        emq.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/can_rx_destuff.md
# can_rx_destuff

Receive-path bit de-stuffer for the CAN 2.0 controller. It sits directly downstream of the bit sampler and consumes its one-bit-per-bit-time sampled stream. It removes stuff bits, flags stuff errors, and forwards the de-stuffed bitstream, a running bit count and assembled bytes to the frame decoder. Stuffing applies only inside the window the frame decoder marks with `en`, from SOF through the end of the CRC sequence.

## Interface
- `STUFF_LEN`, 5: number of consecutive identical bits after which a stuff bit is expected.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: stuff window from the frame decoder. It is high from SOF through the end of the CRC.
- `din` input 1: sampled bus bit from the sampler's `dout`.
- `din_valid` input 1: one-cycle strobe from the sampler's `dvalid`, one per bit time.
- `dout` output 1: de-stuffed bit.
- `dout_valid` output 1: one-cycle strobe qualifying `dout`.
- `byte_out` output 8: last 8 de-stuffed bits, MSB = first received.
- `byte_valid` output 1: one-cycle strobe on the cycle every 8th de-stuffed bit is emitted.
- `bit_cnt` output 8: de-stuffed bits emitted since the window opened; saturates at 255.
- `stuff_err` output 1: stuff error flag, level output.

## Operation
- States: IDLE, RUN, ERR.
  - IDLE → RUN when `en`=1.
  - RUN → ERR on a stuff error.
  - RUN or ERR → IDLE when `en`=0.
- `din_valid` is processed only when `en`=1 (in IDLE or RUN). A bit strobed in the same cycle IDLE sees `en` rise is processed as the first bit of the window.
- Internal state: `last` (previous bus bit) and `run` (0..STUFF_LEN, count of identical consecutive bits).
  - Entering from IDLE sets `run`=0, `bit_cnt`=0, clears the byte shifter and clears `stuff_err`.
- Each processed bit in RUN (or in IDLE with `en`=1):
  - If `run`=STUFF_LEN and `din`≠`last`: stuff bit. Drop it (no `dout_valid`), then set `run`=1, `last`=`din`. The stuff bit starts a new run.
  - If `run`=STUFF_LEN and `din`=`last`: stuff error. Set `stuff_err`=1, go to ERR, no output.
  - Otherwise: emit `dout`=`din` with `dout_valid`=1. Set `run`=`run`+1 if `din`=`last` (or `run`=0), else `run`=1; set `last`=`din`.
- Emitted bits:
  - Shift into `byte_out` MSB-first.
  - Increment `bit_cnt` (saturating).
  - On every 8th emitted bit, pulse `byte_valid` together with `dout_valid`.
- ERR: all `din_valid` is ignored. `stuff_err` holds at 1 through ERR and the following IDLE, and clears only when a new window opens.
- `en` falling mid-byte discards the partial byte; no `byte_valid` is issued.
- `bit_cnt` and `byte_out` hold their values in IDLE.

## Timing
- All outputs are registered.
- `dout`, `dout_valid`, `byte_valid`, `bit_cnt` and `byte_out` update on the clock edge after the `din_valid` cycle (latency 1).
- `stuff_err` rises 1 cycle after the offending `din_valid`.
- Reset values: `dout`=0, `dout_valid`=0, `byte_out`=0x00, `byte_valid`=0, `bit_cnt`=0, `stuff_err`=0; state=IDLE, `run`=0, `last`=0.
- `rst` dominates `en` and `din_valid` in the same cycle. Reset mid-frame returns to IDLE in 1 cycle with all outputs at reset values.
- `en` low on a `din_valid` cycle: the bit is ignored, and the state is IDLE on the next edge.
- `din_valid` pulses are assumed at least 2 cycles apart; at 100 MHz / 1 Mb/s they are 100 cycles apart.

## Test plan
- Window open, bits 0,0,0,0,0,1,1,1 → 7 `dout_valid` pulses carrying 0,0,0,0,0,1,1; 6th input dropped; `bit_cnt`=7; `stuff_err`=0.
- Window open, six 0s → 5 bits emitted, `stuff_err`=1 one cycle after the 6th strobe. Further strobes produce no output; `stuff_err` clears only after `en` falls and rises again.
- Chained stuffing: 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff),1 → outputs 1,1,1,1,1,0,0,0,0,1; both stuff bits dropped; no error.
- Bits 1,0,1,0,1,0,1,0 → `byte_valid` one cycle after the 8th strobe with `byte_out`=0xAA, `bit_cnt`=8. Then 3 more bits and `en`=0 → no further `byte_valid`.
- `rst` pulsed after 20 bits mid-frame → next cycle all outputs at reset values and state IDLE. A new window starts with `bit_cnt` counting from 1.
- `en` deasserted on the same cycle as a `din_valid` → the bit is not emitted and `bit_cnt` is unchanged.
